uart_rx_deserializer: RTL and testbench

- UART receive frame engine; sits directly downstream of the start-bit detector and the bit-rate sampling strobe generator.
- Walks a frame state machine on each sampling_strobe: start bit, data LSB-first, optional parity, stop.
- Shifts data into a parallel word and raises a one-cycle valid pulse with parity/framing status.
- State encoding matches the Rx frame encoding used across the Rx path (IDLE=0, START=1, DATA_k=2+k, PARITY, STOP).

---
 rtl/uart_rx_deserializer_if.sv | 39 +++
 rtl/uart_rx_deserializer.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if
//   Bundles the receive-side signals of the UART frame engine.
//   master : the deserializer (samples line/strobe, drives frame results)
//   slave  : upstream line/strobe source plus downstream consumer
//   Signals: serial_in_synced, sampling_strobe (to engine);
//            state, rx_busy, rx_data, rx_valid, parity_error,
//            framing_error, break_detected (only with RX_BREAK_DETECT_EN).
interface uart_rx_deserializer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int STATE_WIDTH = $clog2(DATA_WIDTH + 4)
);
  logic                   serial_in_synced;
  logic                   sampling_strobe;
  logic [STATE_WIDTH-1:0] state;
  logic                   rx_busy;
  logic [DATA_WIDTH-1:0]  rx_data;
  logic                   rx_valid;
  logic                   parity_error;
  logic                   framing_error;
`ifdef RX_BREAK_DETECT_EN
  logic                   break_detected;
`endif

  modport master (
    input  serial_in_synced, sampling_strobe,
`ifdef RX_BREAK_DETECT_EN
    output break_detected,
`endif
    output state, rx_busy, rx_data, rx_valid, parity_error, framing_error
  );

  modport slave (
    output serial_in_synced, sampling_strobe,
`ifdef RX_BREAK_DETECT_EN
    input  break_detected,
`endif
    input  state, rx_busy, rx_data, rx_valid, parity_error, framing_error
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//   UART receive frame engine. Steps a frame FSM on each sampling_strobe
//   (start, data LSB-first, optional parity, stop), assembles the data word
//   and emits a one-clk rx_valid with parity/framing status.
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset
//   rx     - uart_rx_deserializer_if.master (line/strobe in, frame results out)
// State encoding: IDLE=0, START=1, DATA_k=2+k, PARITY=W+2, STOP=W+3; the
// state names the bit sampled at the most recent strobe.
// Optional feature macro: RX_BREAK_DETECT_EN adds break_detected; an all-zero
// frame (data, parity, stop) then pulses break_detected instead of rx_valid
// and the engine ignores the line until a strobe samples it high.
module uart_rx_deserializer #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED   = 1,
  parameter int PARITY_ODD       = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_rx_deserializer_if.master rx
);
  localparam int W  = INPUT_DATA_WIDTH;
  localparam int SW = $clog2(W + 4);

  typedef enum logic [SW-1:0] {
    IDLE      = SW'(0),
    START     = SW'(1),
    DATA_0    = SW'(2),
    DATA_LAST = SW'(W + 1),
    PARITY    = SW'(W + 2),
    STOP      = SW'(W + 3)
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic           par_q, par_d;     // XOR of data bits and parity bit so far
  logic           pbit_q, pbit_d;   // captured parity bit (break qualification)
  logic [W-1:0]   rx_data_q;
  logic           rx_valid_q;
  logic           perr_q, ferr_q;
  logic           complete;         // stop bit sampled on this strobe, normal frame
  logic           line;
  logic           strobe;
  logic           hold;             // ignore start bits until line seen high

  assign line   = rx.serial_in_synced;
  assign strobe = rx.sampling_strobe;

`ifdef RX_BREAK_DETECT_EN
  logic hold_q, hold_d;
  logic brk_q, brk_d;
  assign hold = hold_q;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    par_d    = par_q;
    pbit_d   = pbit_q;
    complete = 1'b0;
`ifdef RX_BREAK_DETECT_EN
    hold_d   = hold_q;
    brk_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (strobe) begin
          if (hold) begin
`ifdef RX_BREAK_DETECT_EN
            if (line) hold_d = 1'b0;
`endif
          end else if (!line) begin
            state_d = START;
            shift_d = '0;
            par_d   = 1'b0;
            pbit_d  = 1'b0;
          end
        end
      end
      START: begin
        if (strobe) begin
          state_d = DATA_0;
          shift_d = {line, shift_q[W-1:1]};
          par_d   = par_q ^ line;
        end
      end
      STOP: begin
        if (strobe) begin
          // Back-to-back frames: a low stop-slot follower is the next start bit.
          if (!line && !hold) begin
            state_d = START;
            shift_d = '0;
            par_d   = 1'b0;
            pbit_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        if (state_q >= DATA_0 && state_q < DATA_LAST) begin
          if (strobe) begin
            state_d = state_t'(state_q + SW'(1));
            shift_d = {line, shift_q[W-1:1]};
            par_d   = par_q ^ line;
          end
        end else if (state_q == DATA_LAST && PARITY_ENABLED != 0) begin
          if (strobe) begin
            state_d = PARITY;
            par_d   = par_q ^ line;
            pbit_d  = line;
          end
        end else if (state_q == DATA_LAST ||
                     (state_q == PARITY && PARITY_ENABLED != 0)) begin
          // This strobe samples the stop bit.
          if (strobe) begin
            state_d  = STOP;
            complete = 1'b1;
`ifdef RX_BREAK_DETECT_EN
            if (shift_q == '0 && !pbit_q && !line) begin
              complete = 1'b0;
              brk_d    = 1'b1;
              hold_d   = 1'b1;
            end
`endif
          end
        end else begin
          // Unused encoding: recover without touching any output.
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      par_q      <= 1'b0;
      pbit_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      par_q      <= par_d;
      pbit_q     <= pbit_d;
      rx_valid_q <= complete;
      if (complete) begin
        rx_data_q <= shift_q;
        ferr_q    <= !line;
        perr_q    <= (PARITY_ENABLED != 0) ? (par_q != 1'(PARITY_ODD)) : 1'b0;
      end
    end
  end

`ifdef RX_BREAK_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      brk_q  <= brk_d;
    end
  end
  assign rx.break_detected = brk_q;
`endif

  assign rx.state         = state_q;
  assign rx.rx_busy       = (state_q != IDLE);
  assign rx.rx_data       = rx_data_q;
  assign rx.rx_valid      = rx_valid_q;
  assign rx.parity_error  = perr_q;
  assign rx.framing_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer
//   Directed frames (W=8, even parity). Stimulus pushes the expected frame
//   result into a queue; a monitor pops and compares on each rx_valid
//   (or break_detected) pulse.
module tb_uart_rx_deserializer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_deserializer_if #(.DATA_WIDTH(8)) bus();

  uart_rx_deserializer #(
    .INPUT_DATA_WIDTH(8),
    .PARITY_ENABLED  (1),
    .PARITY_ODD      (0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sample on negedge, away from the active edge.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rx_valid) begin
        chk("rx_valid_width", {31'd0, prev_v}, 32'd0);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rx_valid: got rx_data %0h expected no frame", bus.rx_data);
        end else begin
          e = exp_q.pop_front();
          chk("frame_kind",    {31'd0, e.brk}, 32'd0);
          chk("rx_data",       {24'd0, bus.rx_data}, {24'd0, e.data});
          chk("parity_error",  {31'd0, bus.parity_error}, {31'd0, e.perr});
          chk("framing_error", {31'd0, bus.framing_error}, {31'd0, e.ferr});
        end
      end
`ifdef RX_BREAK_DETECT_EN
      if (bus.break_detected) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_break: got break_detected 1 expected no frame");
        end else begin
          e = exp_q.pop_front();
          chk("break_kind", {31'd0, e.brk}, 32'd1);
        end
      end
`endif
      prev_v = bus.rx_valid;
    end
  end

  // One bit period = 16 clk; strobe mid-period. exp_state < 0 skips the check.
  task automatic send_bit(input logic b, input int exp_state);
    bus.serial_in_synced = b;
    repeat (8) @(negedge clk);
    bus.sampling_strobe = 1'b1;
    @(negedge clk);
    bus.sampling_strobe = 1'b0;
    if (exp_state >= 0) begin
      chk("state",   {28'd0, bus.state}, exp_state);
      chk("rx_busy", {31'd0, bus.rx_busy}, {31'd0, (exp_state != 0)});
    end
    repeat (7) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input logic eperr, input logic eferr,
                            input logic ebrk, input bit idle_after);
    exp_t e;
    e.data = d; e.perr = eperr; e.ferr = eferr; e.brk = ebrk;
    exp_q.push_back(e);
    send_bit(1'b0, 1);
    for (int k = 0; k < 8; k++) send_bit(d[k], 2 + k);
    send_bit(p, 10);
    send_bit(s, 11);
    if (idle_after) send_bit(1'b1, 0);
  endtask

  initial begin
    logic [7:0] partial;
    bus.serial_in_synced = 1'b1;
    bus.sampling_strobe  = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state",    {28'd0, bus.state}, 32'd0);
    chk("reset_busy",     {31'd0, bus.rx_busy}, 32'd0);
    chk("reset_data",     {24'd0, bus.rx_data}, 32'd0);
    chk("reset_valid",    {31'd0, bus.rx_valid}, 32'd0);
    chk("reset_perr",     {31'd0, bus.parity_error}, 32'd0);
    chk("reset_ferr",     {31'd0, bus.framing_error}, 32'd0);

    // Idle line: no frame activity.
    for (int i = 0; i < 20; i++) send_bit(1'b1, 0);
    chk("idle_data", {24'd0, bus.rx_data}, 32'd0);
    chk("idle_errs", {30'd0, bus.parity_error, bus.framing_error}, 32'd0);

    // Good frame, even parity (0xA5 has four ones).
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    // Wrong parity bit.
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    // Stop bit low: framing error, data still delivered.
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);

`ifdef RX_BREAK_DETECT_EN
    // Break: pulses break_detected, engine waits for line high.
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    chk("break_keeps_data", {24'd0, bus.rx_data}, 32'h81);
    send_bit(1'b1, 0);
`else
    // All-zero frame completes normally with a framing error.
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
`endif

    // Back-to-back frames: STOP goes straight to START.
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);

    // Reset in DATA_4 aborts the frame silently.
    partial = 8'hFF;
    send_bit(1'b0, 1);
    for (int k = 0; k < 5; k++) send_bit(partial[k], 2 + k);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midframe_reset_state", {28'd0, bus.state}, 32'd0);
    chk("midframe_reset_data",  {24'd0, bus.rx_data}, 32'd0);
    send_bit(1'b1, 0);
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);

    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("rx_data_held",  {24'd0, bus.rx_data}, 32'h0F);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
